// File: rtl/nd_array_packer_if.sv
// Handshake and frame bus between a row-major element stream and the nd_array_packer.
// When ND_ARRAY_PACKER_LAST_CHECK_EN is defined, the bus also carries I_last and O_err.
interface nd_array_packer_if #(
  parameter int ROWS  = 12,
  parameter int COLS  = 16,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]                       I_data;
  logic                                   I_valid;
  logic                                   I_ready;
  logic                                   I_tag__0;
  logic [2:0]                             I_tag__1;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   O0;
  logic                                   O1__0;
  logic [2:0]                             O1__1;
  logic                                   O_valid;
  logic                                   O_ready;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
  logic                                   I_last;
  logic                                   O_err;

  modport master (
    output I_data, I_valid, I_tag__0, I_tag__1, I_last, O_ready,
    input  I_ready, O0, O1__0, O1__1, O_valid, O_err
  );

  modport slave (
    input  I_data, I_valid, I_tag__0, I_tag__1, I_last, O_ready,
    output I_ready, O0, O1__0, O1__1, O_valid, O_err
  );
`else
  modport master (
    output I_data, I_valid, I_tag__0, I_tag__1, O_ready,
    input  I_ready, O0, O1__0, O1__1, O_valid
  );

  modport slave (
    input  I_data, I_valid, I_tag__0, I_tag__1, O_ready,
    output I_ready, O0, O1__0, O1__1, O_valid
  );
`endif
endinterface

// File: rtl/nd_array_packer.sv
// Packs a row-major element stream into a ROWS x COLS frame and holds it until consumed.
// Optional ND_ARRAY_PACKER_LAST_CHECK_EN adds I_last framing with an O_err flag.
//
// state  | meaning
// S_FILL | accepting elements, writing O0[row][col]
// S_HOLD | complete frame presented on O0/O1 with O_valid=1
module nd_array_packer #(
  parameter int ROWS  = 12,
  parameter int COLS  = 16,
  parameter int WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RESETN,
  nd_array_packer_if.slave bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                               state_q, state_d;
  logic [RW-1:0]                        row_q, row_d;
  logic [CW-1:0]                        col_q, col_d;
  logic                                 tag0_q, tag0_d;
  logic [2:0]                           tag1_q, tag1_d;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] frame_q;

  logic accept;
  logic at_first;
  logic at_final;
  logic end_frame;

`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    accept    = bus.I_valid & (state_q == S_FILL);
    at_first  = (row_q == '0) && (col_q == '0);
    at_final  = (row_q == ROW_LAST) && (col_q == COL_LAST);
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
    end_frame = at_final | bus.I_last;
`else
    end_frame = at_final;
`endif

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
    err_d   = err_q;
`endif

    if (state_q == S_FILL) begin
      if (accept) begin
        if (at_first) begin
          tag0_d = bus.I_tag__0;
          tag1_d = bus.I_tag__1;
        end
        if (end_frame) begin
          state_d = S_HOLD;
          row_d   = '0;
          col_d   = '0;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
          // Error unless the count and the I_last marker agree on the final element.
          err_d   = ~(at_final & bus.I_last);
`endif
        end else if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end else begin
      if (bus.O_ready) begin
        state_d = S_FILL;
        row_d   = '0;
        col_d   = '0;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
        err_d   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_FILL;
      row_q   <= '0;
      col_q   <= '0;
      tag0_q  <= 1'b0;
      tag1_q  <= '0;
      frame_q <= '0;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
      err_q   <= err_d;
`endif
      // row/col never leave their ranges, so the write index is always legal.
      if (accept) begin
        frame_q[row_q][col_q] <= bus.I_data;
      end
    end
  end

  assign bus.I_ready = (state_q == S_FILL);
  assign bus.O_valid = (state_q == S_HOLD);
  assign bus.O0      = frame_q;
  assign bus.O1__0   = tag0_q;
  assign bus.O1__1   = tag1_q;
`ifdef ND_ARRAY_PACKER_LAST_CHECK_EN
  assign bus.O_err   = err_q;
`endif

endmodule

// File: doc/nd_array_packer.md
ND_ARRAY_PACKER -- requirements
Module: nd_array_packer

Interface
REQ-001 Parameter ROWS, default 12: number of rows in the packed array.
REQ-002 Parameter COLS, default 16: number of columns per row.
REQ-003 Parameter WIDTH, default 8: bits per element.
REQ-004 Clocking and reset SHALL be exactly: one clock; reset is synchronous and active-low.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RESETN  input  1  synchronous active-low reset.
REQ-007 I_data  input  WIDTH  streamed element, row-major order.
REQ-008 I_valid  input  1  I_data is valid this cycle.
REQ-009 I_ready  output  1  packer accepts an element this cycle.
REQ-010 I_tag__0  input  1  sideband flag for the frame, sampled with the first element.
REQ-011 I_tag__1  input  3  sideband code for the frame, sampled with the first element.
REQ-012 O0  output  [WIDTH-1:0] x [ROWS-1:0][COLS-1:0]  packed frame; O0[r][c] is element r*COLS+c.
REQ-013 O1__0  output  1  captured I_tag__0 of the held frame.
REQ-014 O1__1  output  3  captured I_tag__1 of the held frame.
REQ-015 O_valid  output  1  a complete frame is held on O0/O1.
REQ-016 O_ready  input  1  downstream consumes the held frame.

Function
REQ-017 Two states, FILL and HOLD; I_ready SHALL equal (state==FILL), combinational from state only.
REQ-018 Accept = I_valid & I_ready; on accept, I_data SHALL be written to O0[row][col] at that edge.
REQ-019 On accept col SHALL increment; at col==COLS-1 col wraps to 0 and row increments.
REQ-020 On accept at row==0, col==0, I_tag__0/I_tag__1 SHALL be captured into O1__0/O1__1.
REQ-021 Accept at row==ROWS-1, col==COLS-1 SHALL move to HOLD; O_valid SHALL be 1 from the next cycle (1-cycle latency).
REQ-022 In FILL, O_valid SHALL be 0; I_valid low SHALL stall with no state change (no gaps counted).
REQ-023 In HOLD, O0, O1__0, O1__1 SHALL be stable and no element accepted.
REQ-024 In HOLD, O_valid & O_ready SHALL return to FILL with row=col=0 next cycle; O_valid drops that cycle.
REQ-025 O_ready in FILL SHALL have no effect; O0 contents SHALL persist until overwritten.
REQ-026 Sustained throughput: one element per cycle in FILL; frame period ROWS*COLS+1 cycles with O_ready held high.
REQ-027 Counters SHALL be sized ceil(log2(ROWS)) and ceil(log2(COLS)) bits (min 1); no out-of-range index SHALL ever be written.

Reset
REQ-028 RESETN low at a rising edge SHALL set state=FILL, row=col=0, O_valid=0, O1__0=0, O1__1=0, all O0 elements=0.
REQ-029 Reset SHALL take priority over accept and handoff in the same cycle; a mid-frame reset discards the partial frame.
REQ-030 I_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 Macro ND_ARRAY_PACKER_LAST_CHECK_EN SHALL, when defined, add input I_last (1 bit) and output O_err (1 bit).
REQ-032 With it: I_last on a non-final accept SHALL end the frame early (go to HOLD, O_err=1, unwritten elements keep prior values).
REQ-033 With it: final accept with I_last=0 SHALL go to HOLD with O_err=1; I_last=1 on final accept gives O_err=0.
REQ-034 With it: O_err SHALL be valid whenever O_valid=1, reset to 0, cleared on handoff.
REQ-035 Without it: I_last and O_err ports SHALL not exist and framing is by count only.

Verification
REQ-036 Reset, then 192 back-to-back elements 0..191 (mod 256), tag (1,5) on first -> O_valid cycle 193, O0[11][15]=191, O0[0][3]=3, O1__0=1, O1__1=5.
REQ-037 Hold O_ready=0 for 20 cycles after O_valid -> I_ready=0, O0 unchanged, no accepts; O_ready=1 -> FILL next cycle.
REQ-038 I_valid toggled 1/0 every cycle over a frame -> O_valid after 383 cycles, same contents as REQ-036.
REQ-039 Reset asserted after 100 accepts -> all O0=0, row=col=0; next 192 elements form a correct frame.
REQ-040 O_ready held high, two frames back-to-back -> second O_valid exactly 193 cycles after first, tags of second frame on O1.
REQ-041 With LAST_CHECK_EN: I_last on accept 50 -> HOLD, O_err=1, O0[3][1]=49; next frame with I_last on accept 192 -> O_err=0.
